spike_time_encoder: RTL and testbench
=====================================

// Module: spike_time_encoder
// PURPOSE
//  Temporal (race-logic) encoder that drives a column's input_spikes and grst.
//  Accepts one vector of per-input spike times per gamma cycle over a valid/ready handshake.
//  During the window it raises each input_spikes bit at its spike time and holds it high.
//  It then clears all spikes and pulses grst to close the gamma cycle before taking the next vector.
// PARAMETERS
//  NUM_INPUTS   4   number of spike lines driven into the column
//  TRES         3   spike-time resolution in bits; time value (1<<TRES)-1 = NOSPIKE
//  WINDOW       16  gamma window length in clk cycles; must be >= (1<<TRES)-1
//  GRST_CYCLES  2   number of cycles grst is held high at end of each gamma cycle
// PORTS
//  clk           in   1                clock, all state on rising edge
//  rstb          in   1                reset, synchronous, active-low
//  in_valid      in   1                spike-time vector available
//  in_ready      out  1                encoder idle and able to accept a vector
//  in_times      in   [NUM_INPUTS][TRES]  per-input spike time; all-ones = no spike
//  flush         in   1                abort current window, go straight to grst phase
//  input_spikes  out  NUM_INPUTS       spike lines to column, driven from flops
//  grst          out  1                gamma reset to column, driven from flop
//  busy          out  1                high in RUN and CLEAR
//  gamma_done    out  1                one-cycle pulse on last grst cycle
// BEHAVIOUR
//  Reset (rstb=0 at an edge):
//   - state=IDLE; cnt=0; latched times=all-ones.
//   - input_spikes=0; grst=0; busy=0; gamma_done=0; in_ready=1 from the next cycle.
//   - Reset mid-RUN/CLEAR aborts immediately; no grst pulse is issued.
//  FSM states: IDLE, RUN, CLEAR.
//  IDLE:
//   - in_ready=1; outputs low.
//   - in_valid=1 at an edge: latch in_times, cnt<=0, go to RUN.
//   - flush is ignored in IDLE, including when it coincides with accept.
//  RUN:
//   - in_ready=0; busy=1.
//   - cnt counts 0..WINDOW-1; cnt is the cycle index t after the accept edge.
//   - In cycle t, input_spikes[i] = (time_i != NOSPIKE) && (t >= time_i).
//   - A spike at time 0 is therefore high in the first RUN cycle. Spikes never fall inside RUN.
//   - cnt==WINDOW-1 at an edge: go to CLEAR, cnt<=0.
//   - flush=1 at any RUN edge (including cnt==WINDOW-1): go to CLEAR, cnt<=0.
//  CLEAR:
//   - input_spikes=0; grst=1 for exactly GRST_CYCLES cycles; busy=1.
//   - gamma_done=1 in the final CLEAR cycle only.
//   - Then go to IDLE, with in_ready=1 in the following cycle.
//   - flush in CLEAR is ignored and does not restart the count.
//  Throughput: one vector per WINDOW+GRST_CYCLES+1 cycles; in_valid may stay high back-to-back.
//  Width rules:
//   - cnt is $clog2(WINDOW) bits.
//   - Compare t >= time_i with time_i zero-extended to cnt width.
//   - Counters saturate at their terminal value, never wrap.
// TESTING
//  1. Reset, times={7,2,0,1}, WINDOW=16:
//     - spikes[2] high at t=0, [3] at t=1, [1] at t=2; [0] never.
//     - All low at t=16; grst high t=16..17; gamma_done at t=17; in_ready at t=18.
//  2. Back-to-back: in_valid held high with two vectors:
//     - second accept exactly 19 cycles after first.
//     - No spike from vector 1 is visible in vector 2's window.
//  3. flush asserted at t=5 of the window with times={0,3,6,7}:
//     - spikes[0],[1] cleared and grst high from t=6 for 2 cycles; [2] never rises.
//  4. flush together with accept in IDLE:
//     - vector accepted, full 16-cycle window runs; flush has no effect.
//  5. rstb low for one edge at t=8 of RUN:
//     - next cycle all outputs 0, no grst pulse, in_ready=1.
//     - New vector accepted normally after.
//  6. All inputs NOSPIKE:
//     - input_spikes stays 0 for the whole window; grst/gamma_done still pulse on schedule.

Source files
------------

// File: rtl/spike_time_encoder_if.sv
// Spike-time encoder port bundle: vector handshake in, column spike lines and gamma reset out.
interface spike_time_encoder_if #(
  parameter int NUM_INPUTS = 4,
  parameter int TRES       = 3
);
  logic                                in_valid;
  logic                                in_ready;
  logic [NUM_INPUTS-1:0][TRES-1:0]     in_times;
  logic                                flush;
  logic [NUM_INPUTS-1:0]               input_spikes;
  logic                                grst;
  logic                                busy;
  logic                                gamma_done;

  modport master (
    output in_valid, in_times, flush,
    input  in_ready, input_spikes, grst, busy, gamma_done
  );
  modport slave (
    input  in_valid, in_times, flush,
    output in_ready, input_spikes, grst, busy, gamma_done
  );
endinterface

// File: rtl/spike_time_encoder.sv
// Race-logic encoder: one spike-time vector per gamma cycle, spikes rise at their time
// and hold, then a GRST_CYCLES grst pulse closes the cycle.
module spike_time_lane #(
  parameter int TRES = 3,
  parameter int CW   = 4
) (
  input  logic            run,
  input  logic [TRES-1:0] t,
  input  logic [CW-1:0]   cnt,
  output logic            hit
);
  localparam logic [TRES-1:0] NOSPIKE = '1;
  assign hit = run && (t != NOSPIKE) && (cnt >= CW'(t));
endmodule

module spike_time_encoder #(
  parameter int NUM_INPUTS  = 4,
  parameter int TRES        = 3,
  parameter int WINDOW      = 16,
  parameter int GRST_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rstb,
  spike_time_encoder_if.slave s
);
  localparam int          CW       = $clog2(WINDOW);
  localparam logic [CW-1:0] LAST_RUN = CW'(WINDOW - 1);
  localparam logic [CW-1:0] LAST_CLR = CW'(GRST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  state_t                          state, state_d;
  logic [CW-1:0]                   cnt, cnt_d;
  logic [NUM_INPUTS-1:0][TRES-1:0] times_q, times_d;
  logic [NUM_INPUTS-1:0]           spikes_q, spikes_d;
  logic                            grst_q, grst_d;
  logic                            done_q, done_d;
  logic                            busy_q, busy_d;
  logic                            run_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    times_d = times_q;
    case (state)
      IDLE: if (s.in_valid) begin
        times_d = s.in_times;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: if (s.flush || cnt == LAST_RUN) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end else cnt_d = cnt + 1'b1;
      CLEAR: if (cnt == LAST_CLR) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt + 1'b1;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // outputs are registered, so they are decoded from the upcoming state/count
    run_d  = (state_d == RUN);
    grst_d = (state_d == CLEAR);
    done_d = (state_d == CLEAR) && (cnt_d == LAST_CLR);
    busy_d = (state_d != IDLE);
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    spike_time_lane #(.TRES(TRES), .CW(CW)) u_lane (
      .run (run_d),
      .t   (times_d[i]),
      .cnt (cnt_d),
      .hit (spikes_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state    <= IDLE;
      cnt      <= '0;
      times_q  <= '1;
      spikes_q <= '0;
      grst_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      times_q  <= times_d;
      spikes_q <= spikes_d;
      grst_q   <= grst_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign s.in_ready     = (state == IDLE);
  assign s.input_spikes = spikes_q;
  assign s.grst         = grst_q;
  assign s.gamma_done   = done_q;
  assign s.busy         = busy_q;
endmodule

// File: tb/tb_spike_time_encoder.sv
// Bench for spike_time_encoder: per-cycle expectations queued at accept, popped at each negedge.
module tb_spike_time_encoder;
  localparam int N      = 4;
  localparam int TRES   = 3;
  localparam int WINDOW = 16;
  localparam int GRST   = 2;
  localparam logic [TRES-1:0] NOSPIKE = '1;

  typedef logic [N-1:0][TRES-1:0] times_t;
  typedef struct {
    logic [N-1:0] spk;
    logic grst, done, busy, rdy;
  } exp_t;
  typedef struct {
    times_t       times;
    bit           flush_acc;
    int           flush_at;
    int           rst_at;
    logic [N-1:0] spk_last;
    int           grst_t;
  } tv_t;

  logic clk, rstb;
  int   checks, failures, cyc;
  exp_t sbq[$];
  int   acc_log[$];
  tv_t  tv[6];

  spike_time_encoder_if #(.NUM_INPUTS(N), .TRES(TRES)) ifc ();
  spike_time_encoder #(.NUM_INPUTS(N), .TRES(TRES), .WINDOW(WINDOW), .GRST_CYCLES(GRST))
    dut (.clk(clk), .rstb(rstb), .s(ifc));

  initial clk = 0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstb && ifc.in_valid && ifc.in_ready) acc_log.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
    end
  endtask

  function automatic void push_idle();
    exp_t e;
    e.spk = '0; e.grst = 0; e.done = 0; e.busy = 0; e.rdy = 1;
    sbq.push_back(e);
  endfunction

  function automatic void push_window(input times_t tm, input int flush_at);
    int   len = (flush_at >= 0) ? flush_at + 1 : WINDOW;
    exp_t e;
    for (int t = 0; t < len; t++) begin
      for (int i = 0; i < N; i++) e.spk[i] = (tm[i] != NOSPIKE) && (t >= int'(tm[i]));
      e.grst = 0; e.done = 0; e.busy = 1; e.rdy = 0;
      sbq.push_back(e);
    end
    for (int g = 0; g < GRST; g++) begin
      e.spk = '0; e.grst = 1; e.done = (g == GRST - 1); e.busy = 1; e.rdy = 0;
      sbq.push_back(e);
    end
    push_idle();
  endfunction

  task automatic check_cycle(input int t);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", t, 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk("spikes",     t, ifc.input_spikes, e.spk);
    chk("grst",       t, ifc.grst,         e.grst);
    chk("gamma_done", t, ifc.gamma_done,   e.done);
    chk("busy",       t, ifc.busy,         e.busy);
    chk("in_ready",   t, ifc.in_ready,     e.rdy);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50 && ifc.in_ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    chk("ready_wait", 0, ifc.in_ready, 1);
  endtask

  task automatic run_vec(input tv_t v);
    wait_ready();
    ifc.in_times = v.times;
    ifc.in_valid = 1;
    ifc.flush    = v.flush_acc;
    @(posedge clk); #1;
    ifc.in_valid = 0;
    ifc.flush    = 0;
    push_window(v.times, v.flush_at);
    for (int t = 0; sbq.size() > 0 && t < 100; t++) begin
      ifc.flush = (t == v.flush_at);
      if (t == v.rst_at) rstb = 0;
      @(negedge clk);
      check_cycle(t);
      if (t == v.grst_t) chk("grst_rise", t, ifc.grst, 1);
      if (t == v.grst_t - 1 && v.rst_at < 0) chk("spk_last_run", t, ifc.input_spikes, v.spk_last);
      @(posedge clk); #1;
      if (t == v.rst_at) begin
        rstb = 1;
        sbq.delete();
        repeat (3) push_idle();
      end
    end
    ifc.flush = 0;
  endtask

  initial begin
    times_t ta, tb;
    checks = 0; failures = 0;
    //          times                         flush_acc flush_at rst_at spk_last grst_t
    tv[0] = '{ {3'd1, 3'd0, 3'd2, 3'd7}, 1'b0, -1, -1, 4'b1110, 16 };
    tv[1] = '{ {3'd7, 3'd6, 3'd3, 3'd0}, 1'b0,  5, -1, 4'b0011,  6 };
    tv[2] = '{ {3'd7, 3'd5, 3'd3, 3'd1}, 1'b1, -1, -1, 4'b0111, 16 };
    tv[3] = '{ {3'd0, 3'd7, 3'd2, 3'd4}, 1'b0, -1,  8, 4'b0000, -1 };
    tv[4] = '{ {3'd7, 3'd7, 3'd7, 3'd7}, 1'b0, -1, -1, 4'b0000, 16 };
    tv[5] = '{ {3'd3, 3'd4, 3'd5, 3'd6}, 1'b0, 15, -1, 4'b1111, 16 };

    rstb = 0; ifc.in_valid = 0; ifc.flush = 0; ifc.in_times = '1;
    @(posedge clk);
    @(negedge clk);
    push_idle();
    check_cycle(-1);
    @(posedge clk); #1;
    rstb = 1;

    for (int k = 0; k < 6; k++) run_vec(tv[k]);

    // back-to-back: in_valid held high across two vectors
    ta = {3'd0, 3'd0, 3'd0, 3'd0};
    tb = {3'd5, 3'd7, 3'd7, 3'd7};
    wait_ready();
    acc_log.delete();
    ifc.in_times = ta;
    ifc.in_valid = 1;
    @(posedge clk); #1;
    ifc.in_times = tb;
    push_window(ta, -1);
    for (int t = 0; t < 38; t++) begin
      @(negedge clk);
      check_cycle(t);
      if (t == WINDOW + GRST) push_window(tb, -1);
      @(posedge clk); #1;
      if (t == WINDOW + GRST) ifc.in_valid = 0;
    end
    chk("b2b_accepts", 0, acc_log.size(), 2);
    if (acc_log.size() >= 2) chk("b2b_spacing", 0, acc_log[1] - acc_log[0], WINDOW + GRST + 1);

    // flush during CLEAR must not restart the grst count
    wait_ready();
    ifc.in_times = {3'd2, 3'd2, 3'd2, 3'd2};
    ifc.in_valid = 1;
    @(posedge clk); #1;
    ifc.in_valid = 0;
    push_window(ifc.in_times, -1);
    for (int t = 0; t < WINDOW + GRST + 1; t++) begin
      ifc.flush = (t >= WINDOW);
      @(negedge clk);
      check_cycle(t);
      @(posedge clk); #1;
    end
    ifc.flush = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
